// File: rtl/hamming_pkg.sv
// hamming_pkg: shared FSM states, status flags and codeword field mapping for the SECDED (16,11) decoder.
//   state_t   : decode engine FSM states
//   FLG_*     : 2-bit status flag values written to result high byte [7:6]
//   cw_data   : extracts the 11 message bits from a 16-bit codeword
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAP,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [1:0] FLG_OK  = 2'b00;
    localparam logic [1:0] FLG_FIX = 2'b01;
    localparam logic [1:0] FLG_DBL = 2'b10;

    // Data bits sit at the non-power-of-two positions: d1=b3, d4:d2=b7:b5, d11:d5=b15:b9.
    function automatic logic [10:0] cw_data(input logic [15:0] cw);
        return {cw[15:9], cw[7:5], cw[3]};
    endfunction

endpackage

// File: rtl/secded16_decode.sv
// secded16_decode: combinational SECDED (16,11) decode of one codeword.
//   cw       in  16  codeword, bit k = Hamming position k, bit 0 = overall parity
//   data     out 11  message bits (corrected for single errors, raw for double errors)
//   flag     out 2   FLG_OK / FLG_FIX / FLG_DBL
//   syndrome out 4   XOR of the positions of all set bits
module secded16_decode
    import hamming_pkg::*;
(
    input  logic [15:0] cw,
    output logic [10:0] data,
    output logic [1:0]  flag,
    output logic [3:0]  syndrome
);

    logic        parity;
    logic [15:0] fixed;

    always_comb begin
        syndrome = '0;
        for (int k = 1; k < 16; k++)
            if (cw[k]) syndrome = syndrome ^ 4'(k);
    end

    assign parity = ^cw;
    // Odd overall parity means exactly one flipped bit; syndrome 0 then points at p0 itself.
    assign fixed  = parity ? cw ^ (16'd1 << syndrome) : cw;
    assign data   = cw_data(fixed);
    assign flag   = parity ? FLG_FIX : (syndrome != 4'd0 ? FLG_DBL : FLG_OK);

endmodule

// File: rtl/hamming_decode_engine.sv
// hamming_decode_engine: memory-mastering SECDED (16,11) decoder, 5 cycles per codeword.
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle request, honoured in IDLE or DONE
//   done       out  high from completion until the next accepted start
//   mem_addr   out  byte address for the current read or write
//   mem_rd_en  out  read strobe, mem_rdata valid one cycle later
//   mem_rdata  in   read data
//   mem_wr_en  out  write strobe
//   mem_wdata  out  write data
//   err1_cnt   out  saturating count of corrected words this run
//   err2_cnt   out  saturating count of double-error words this run
module hamming_decode_engine
    import hamming_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic [3:0]        err1_cnt,
    output logic [3:0]        err2_cnt
);

    localparam logic [ADDR_W-1:0] SRC  = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST  = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        lo_byte;
    logic [7:0]        hi_byte;
    logic [10:0]       dec_data;
    logic [1:0]        dec_flag;
    logic [3:0]        dec_syn;

    // During CAP the high byte is on mem_rdata and the low byte was captured in RD_HI.
    secded16_decode u_dec (
        .cw       ({mem_rdata, lo_byte}),
        .data     (dec_data),
        .flag     (dec_flag),
        .syndrome (dec_syn)
    );

    // Outputs are registered, so each state's strobes/address are set on the edge entering it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            lo_byte   <= '0;
            hi_byte   <= '0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            err1_cnt  <= '0;
            err2_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RD_LO;
                        done      <= 1'b0;
                        idx       <= '0;
                        err1_cnt  <= '0;
                        err2_cnt  <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= SRC;
                    end
                end
                RD_LO: begin
                    state    <= RD_HI;
                    mem_addr <= mem_addr + 1'b1;
                end
                RD_HI: begin
                    state     <= CAP;
                    lo_byte   <= mem_rdata;
                    mem_rd_en <= 1'b0;
                end
                CAP: begin
                    state     <= WR_LO;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= DST + (idx << 1);
                    mem_wdata <= dec_data[7:0];
                    hi_byte   <= {dec_flag, 3'b000, dec_data[10:8]};
                    if (dec_flag == FLG_FIX && err1_cnt != 4'hF)
                        err1_cnt <= err1_cnt + 4'd1;
                    // Double error: nonzero syndrome that the overall parity did not account for.
                    if (dec_flag != FLG_FIX && dec_syn != 4'd0 && err2_cnt != 4'hF)
                        err2_cnt <= err2_cnt + 4'd1;
                end
                WR_LO: begin
                    state     <= WR_HI;
                    mem_addr  <= mem_addr + 1'b1;
                    mem_wdata <= hi_byte;
                end
                WR_HI: begin
                    mem_wr_en <= 1'b0;
                    if (idx == LAST) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        mem_addr <= '0;
                    end else begin
                        state     <= RD_LO;
                        idx       <= idx + 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= SRC + ((idx + 1'b1) << 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_decode_engine.sv
// tb_hamming_decode_engine: table-driven directed bench for hamming_decode_engine with a byte memory model.
module tb_hamming_decode_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       done, mem_rd_en, mem_wr_en;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic [3:0] err1_cnt, err2_cnt;

    logic [7:0]  mem [256];
    logic [7:0]  img [256];
    logic        load_en = 1'b0;
    logic [15:0] words [15];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hamming_decode_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .err1_cnt  (err1_cnt),
        .err2_cnt  (err2_cnt)
    );

    always @(posedge clk) begin
        if (load_en) mem <= img;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [15:0] cw;
        logic        all;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [3:0]  e1;
        logic [3:0]  e2;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] encode(input logic [10:0] m);
        logic [15:0] c = '0;
        c[3]    = m[0];
        c[7:5]  = m[3:1];
        c[15:9] = m[10:4];
        c[1] = ^(c & 16'hAAAA);
        c[2] = ^(c & 16'hCCCC);
        c[4] = ^(c & 16'hF0F0);
        c[8] = ^(c & 16'hFF00);
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Returns {hi_byte, lo_byte}; syndrome built from per-parity-group masks.
    function automatic logic [15:0] model(input logic [15:0] cw);
        logic [3:0]  s;
        logic [15:0] c = cw;
        logic [1:0]  f;
        s = {^(cw & 16'hFF00), ^(cw & 16'hF0F0), ^(cw & 16'hCCCC), ^(cw & 16'hAAAA)};
        if (^cw) begin
            c[s] = ~c[s];
            f = 2'b01;
        end else begin
            f = (s != 4'd0) ? 2'b10 : 2'b00;
        end
        return {f, 3'b000, c[15:13], c[12:9], c[7:5], c[3]};
    endfunction

    task automatic load_mem();
        for (int a = 0; a < 256; a++) img[a] = (a < 30) ? 8'hAA : 8'h00;
        for (int w = 0; w < 15; w++) begin
            img[30 + 2*w] = words[w][7:0];
            img[31 + 2*w] = words[w][15:8];
        end
        load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // Pulses start, then counts edges until done; extra start at cycle mid, stop early at cycle stop.
    task automatic run(input int mid, input int stop, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("strobe_excl", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
            if (done || cyc == stop) break;
            start = (cyc == mid);
        end
        start = 1'b0;
        if (stop == 0) begin
            chk("done_seen", {31'd0, done}, 32'd1);
            chk("done_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_rd"},   {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_wr"},   {31'd0, mem_wr_en}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_e1"},   {28'd0, err1_cnt}, 32'd0);
        chk({tag, "_e2"},   {28'd0, err2_cnt}, 32'd0);
    endtask

    initial begin
        int          cyc, e1, e2, wr_seen;
        logic [15:0] exp;
        logic [3:0]  b1;

        tv[0] = '{16'h0000, 1'b0, 8'h00, 8'h00, 4'd0, 4'd0};
        tv[1] = '{16'hFFFF, 1'b0, 8'hFF, 8'h07, 4'd0, 4'd0};
        tv[2] = '{16'h0020, 1'b0, 8'h00, 8'h40, 4'd1, 4'd0};
        tv[3] = '{16'hFFFE, 1'b0, 8'hFF, 8'h47, 4'd1, 4'd0};
        tv[4] = '{16'h0003, 1'b0, 8'h00, 8'h80, 4'd0, 4'd1};
        tv[5] = '{16'h7FFF, 1'b0, 8'hFF, 8'h47, 4'd1, 4'd0};
        tv[6] = '{16'h0020, 1'b1, 8'h00, 8'h40, 4'hF, 4'd0};
        tv[7] = '{16'h0003, 1'b1, 8'h00, 8'h80, 4'd0, 4'hF};

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            for (int w = 0; w < 15; w++) words[w] = (w == 0 || tv[v].all) ? tv[v].cw : 16'h0000;
            load_mem();
            run(0, 0, cyc);
            chk($sformatf("v%0d_latency", v), cyc, 75);
            chk($sformatf("v%0d_lo", v), {24'd0, mem[0]}, {24'd0, tv[v].lo});
            chk($sformatf("v%0d_hi", v), {24'd0, mem[1]}, {24'd0, tv[v].hi});
            chk($sformatf("v%0d_e1", v), {28'd0, err1_cnt}, {28'd0, tv[v].e1});
            chk($sformatf("v%0d_e2", v), {28'd0, err2_cnt}, {28'd0, tv[v].e2});
        end

        // Full run of mixed clean / single / double error words with an ignored mid-run start.
        for (int w = 0; w < 15; w++) begin
            words[w] = encode(11'($urandom_range(0, 2047)));
            b1 = 4'($urandom_range(0, 15));
            if (w % 3 >= 1) words[w][b1] = ~words[w][b1];
            if (w % 3 == 2) begin
                b1 = b1 + 4'($urandom_range(1, 15));
                words[w][b1] = ~words[w][b1];
            end
        end
        load_mem();
        run(30, 0, cyc);
        chk("full_latency", cyc, 75);
        e1 = 0;
        e2 = 0;
        for (int w = 0; w < 15; w++) begin
            exp = model(words[w]);
            e1 += (exp[15:14] == 2'b01) ? 1 : 0;
            e2 += (exp[15:14] == 2'b10) ? 1 : 0;
            chk($sformatf("full_lo%0d", w), {24'd0, mem[2*w]},     {24'd0, exp[7:0]});
            chk($sformatf("full_hi%0d", w), {24'd0, mem[2*w + 1]}, {24'd0, exp[15:8]});
        end
        chk("full_e1", {28'd0, err1_cnt}, e1);
        chk("full_e2", {28'd0, err2_cnt}, e2);

        // Reset asserted 20 cycles into a run: four words written, nothing after release.
        for (int w = 0; w < 15; w++) words[w] = encode(11'($urandom_range(0, 2047))) ^ 16'h0100;
        load_mem();
        run(0, 20, cyc);
        chk("rst_cycle", cyc, 20);
        reset = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wr_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            wr_seen += mem_wr_en ? 1 : 0;
        end
        chk("post_rst_writes", wr_seen, 0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        for (int w = 0; w < 4; w++) begin
            exp = model(words[w]);
            chk($sformatf("rst_lo%0d", w), {24'd0, mem[2*w]},     {24'd0, exp[7:0]});
            chk($sformatf("rst_hi%0d", w), {24'd0, mem[2*w + 1]}, {24'd0, exp[15:8]});
        end
        chk("rst_untouched", {24'd0, mem[8]}, 32'hAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
